// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with the architectural NZVC flag register and a retired-operation counter.
// Flush squashes the EX operation and wins over stall; reset wins over both.
module ex_mem_pipe #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_negative,
  input  logic              ex_zero,
  input  logic              ex_overflow,
  input  logic              ex_carry_out,
  input  logic              ex_set_flags,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [4:0]        mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic [3:0]        flags_q,
  output logic [3:0]        flags_fwd,
  output logic [CNT_W-1:0]  retire_count
);

  logic              valid_q,      valid_d;
  logic [DATA_W-1:0] result_q,     result_d;
  logic [DATA_W-1:0] store_q,      store_d;
  logic [4:0]        rd_q,         rd_d;
  logic              reg_write_q,  reg_write_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_write_q,  mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic [3:0]        flag_q,       flag_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;

  logic       advance;
  logic [3:0] ex_flags;

  assign advance  = !stall && !flush;
  assign ex_flags = {ex_negative, ex_zero, ex_overflow, ex_carry_out};

  always_comb begin
    valid_d      = valid_q;
    result_d     = result_q;
    store_d      = store_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    flag_d       = flag_q;
    cnt_d        = cnt_q;
    if (flush) begin
      valid_d      = 1'b0;
      result_d     = '0;
      store_d      = '0;
      rd_d         = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (advance) begin
      valid_d      = ex_valid;
      result_d     = ex_result;
      store_d      = ex_store_data;
      rd_d         = ex_rd;
      // Control bits of a bubble must never reach MEM, whatever EX drives.
      reg_write_d  = ex_valid && ex_reg_write;
      mem_read_d   = ex_valid && ex_mem_read;
      mem_write_d  = ex_valid && ex_mem_write;
      mem_to_reg_d = ex_valid && ex_mem_to_reg;
      if (ex_valid) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ex_set_flags) begin
          flag_d = ex_flags;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      result_q     <= '0;
      store_q      <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      flag_q       <= '0;
      cnt_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      result_q     <= result_d;
      store_q      <= store_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      flag_q       <= flag_d;
      cnt_q        <= cnt_d;
    end
  end

  // A branch resolving alongside a flag-setter sees its flags even while stalled.
  always_comb begin
    flags_fwd = flag_q;
    if (ex_valid && ex_set_flags && !flush) begin
      flags_fwd = ex_flags;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_result     = result_q;
  assign mem_store_data = store_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;
  assign mem_mem_to_reg = mem_to_reg_q;
  assign flags_q        = flag_q;
  assign retire_count   = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: a driver applies operations and queues the expected MEM-stage view,
// a monitor checks forwarded flags before each edge and the registered state after it.
module tb_ex_mem_pipe;

  typedef struct packed {
    logic        valid;
    logic [63:0] result;
    logic [63:0] store;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic [3:0]  flags;
    logic        setf;
  } op_t;

  typedef struct {
    logic        chk_fwd;
    logic [3:0]  fwd;
    op_t         slot;
    logic [3:0]  flags;
    logic [31:0] count;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, st, fl;
  op_t         cur;

  logic        m_valid, w_valid;
  logic [63:0] m_result, m_store, w_result, w_store;
  logic [4:0]  m_rd, w_rd;
  logic        m_rw, m_mr, m_mw, m_m2r, w_rw, w_mr, w_mw, w_m2r;
  logic [3:0]  m_flags, m_fwd, w_flags, w_fwd;
  logic [31:0] m_cnt;
  logic [3:0]  w_cnt;

  ex_mem_pipe #(.DATA_W(64), .CNT_W(32)) dut (
    .clk(clk), .reset(rst), .stall(st), .flush(fl),
    .ex_valid(cur.valid), .ex_result(cur.result),
    .ex_negative(cur.flags[3]), .ex_zero(cur.flags[2]), .ex_overflow(cur.flags[1]), .ex_carry_out(cur.flags[0]),
    .ex_set_flags(cur.setf), .ex_store_data(cur.store), .ex_rd(cur.rd),
    .ex_reg_write(cur.rw), .ex_mem_read(cur.mr), .ex_mem_write(cur.mw), .ex_mem_to_reg(cur.m2r),
    .mem_valid(m_valid), .mem_result(m_result), .mem_store_data(m_store), .mem_rd(m_rd),
    .mem_reg_write(m_rw), .mem_mem_read(m_mr), .mem_mem_write(m_mw), .mem_mem_to_reg(m_m2r),
    .flags_q(m_flags), .flags_fwd(m_fwd), .retire_count(m_cnt)
  );

  ex_mem_pipe #(.DATA_W(64), .CNT_W(4)) dut_w (
    .clk(clk), .reset(rst), .stall(st), .flush(fl),
    .ex_valid(cur.valid), .ex_result(cur.result),
    .ex_negative(cur.flags[3]), .ex_zero(cur.flags[2]), .ex_overflow(cur.flags[1]), .ex_carry_out(cur.flags[0]),
    .ex_set_flags(cur.setf), .ex_store_data(cur.store), .ex_rd(cur.rd),
    .ex_reg_write(cur.rw), .ex_mem_read(cur.mr), .ex_mem_write(cur.mw), .ex_mem_to_reg(cur.m2r),
    .mem_valid(w_valid), .mem_result(w_result), .mem_store_data(w_store), .mem_rd(w_rd),
    .mem_reg_write(w_rw), .mem_mem_read(w_mr), .mem_mem_write(w_mw), .mem_mem_to_reg(w_m2r),
    .flags_q(w_flags), .flags_fwd(w_fwd), .retire_count(w_cnt)
  );

  // Reference model: what the MEM slot holds, the architectural flags and the retire total.
  op_t         md_slot;
  logic [3:0]  md_flags;
  logic [31:0] md_count;
  logic        md_known = 1'b0;
  exp_t        sb[$];

  int unsigned tests = 0;
  int unsigned fails = 0;

  function automatic op_t bubble();
    op_t b;
    b = '0;
    return b;
  endfunction

  function automatic op_t mk(input logic v, input logic [63:0] res, input logic [4:0] rd,
                             input logic [3:0] ctl, input logic [3:0] fl4, input logic sf);
    op_t o;
    o = '0;
    o.valid = v; o.result = res; o.store = ~res; o.rd = rd;
    {o.rw, o.mr, o.mw, o.m2r} = ctl;
    o.flags = fl4; o.setf = sf;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.valid  = ($urandom_range(3) != 0);
    o.result = {$urandom, $urandom};
    o.store  = {$urandom, $urandom};
    o.rd     = 5'($urandom);
    o.rw     = 1'($urandom); o.mr = 1'($urandom); o.mw = 1'($urandom); o.m2r = 1'($urandom);
    o.flags  = 4'($urandom);
    o.setf   = 1'($urandom);
    return o;
  endfunction

  task automatic cycle(input logic r, input logic s, input logic f, input op_t op);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r; st = s; fl = f; cur = op;
    e.chk_fwd = md_known;
    e.fwd = (op.valid && op.setf && !f) ? op.flags : md_flags;
    if (r) begin
      md_slot = bubble(); md_flags = '0; md_count = '0; md_known = 1'b1;
    end else if (f) begin
      md_slot = bubble();
    end else if (!s) begin
      // An operation in MEM carries data as-is; a bubble carries data but no control.
      md_slot = op;
      md_slot.flags = '0; md_slot.setf = 1'b0;
      if (!op.valid) {md_slot.rw, md_slot.mr, md_slot.mw, md_slot.m2r} = '0;
      if (op.valid) begin
        md_count = md_count + 1;
        if (op.setf) md_flags = op.flags;
      end
    end
    e.slot = md_slot; e.flags = md_flags; e.count = md_count;
    sb.push_back(e);
  endtask

  function automatic op_t view(input logic v, input logic [63:0] r, input logic [63:0] s, input logic [4:0] d,
                               input logic a, input logic b, input logic c, input logic e);
    op_t o;
    o = '0;
    o.valid = v; o.result = r; o.store = s; o.rd = d;
    o.rw = a; o.mr = b; o.mw = c; o.m2r = e;
    return o;
  endfunction

  // Monitor: flags_fwd is checked while the cycle's inputs are stable, registered state after the edge.
  initial begin
    exp_t e;
    op_t  act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].chk_fwd) begin
        tests++;
        if (m_fwd !== sb[0].fwd || w_fwd !== sb[0].fwd) begin
          fails++;
          $display("FAIL flags_fwd: got %b/%b expected %b", m_fwd, w_fwd, sb[0].fwd);
        end
      end
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = view(m_valid, m_result, m_store, m_rd, m_rw, m_mr, m_mw, m_m2r);
        tests++;
        if (act !== e.slot) begin
          fails++;
          $display("FAIL mem_slot: got v=%b res=%h st=%h rd=%0d ctl=%b%b%b%b expected v=%b res=%h st=%h rd=%0d ctl=%b%b%b%b",
                   act.valid, act.result, act.store, act.rd, act.rw, act.mr, act.mw, act.m2r,
                   e.slot.valid, e.slot.result, e.slot.store, e.slot.rd, e.slot.rw, e.slot.mr, e.slot.mw, e.slot.m2r);
        end
        act = view(w_valid, w_result, w_store, w_rd, w_rw, w_mr, w_mw, w_m2r);
        tests++;
        if (act !== e.slot) begin
          fails++;
          $display("FAIL mem_slot_cnt4: got v=%b res=%h expected v=%b res=%h", act.valid, act.result, e.slot.valid, e.slot.result);
        end
        tests++;
        if (m_flags !== e.flags || w_flags !== e.flags) begin
          fails++;
          $display("FAIL flags_q: got %b/%b expected %b", m_flags, w_flags, e.flags);
        end
        tests++;
        if (m_cnt !== e.count) begin
          fails++;
          $display("FAIL retire_count: got %0d expected %0d", m_cnt, e.count);
        end
        tests++;
        if (w_cnt !== e.count[3:0]) begin
          fails++;
          $display("FAIL retire_count_wrap: got %0d expected %0d", w_cnt, e.count[3:0]);
        end
      end
    end
  end

  initial begin
    op_t a, b;
    int unsigned guard;
    rst = 1'b0; st = 1'b0; fl = 1'b0; cur = '0;
    md_slot = '0; md_flags = '0; md_count = '0;

    cycle(1, 0, 0, bubble());
    cycle(1, 1, 1, rand_op());
    // Simple advance of an ALU result.
    cycle(0, 0, 0, mk(1, 64'h5, 5'd3, 4'b1000, 4'b0000, 0));
    // SUBS setting Z and C, then an ADD that leaves the flags alone.
    cycle(0, 0, 0, mk(1, 64'h0, 5'd1, 4'b1000, 4'b0101, 1));
    cycle(0, 0, 0, mk(1, 64'h9, 5'd2, 4'b1000, 4'b1010, 0));
    // Capture A, stall three cycles with B in EX, then release B.
    a = mk(1, 64'hAAAA, 5'd10, 4'b1001, 4'b0000, 0);
    b = mk(1, 64'hBBBB, 5'd11, 4'b0010, 4'b1100, 1);
    cycle(0, 0, 0, a);
    repeat (3) cycle(0, 1, 0, b);
    cycle(0, 0, 0, b);
    // Flush together with stall on a flag-setting store.
    cycle(0, 1, 1, mk(1, 64'h77, 5'd7, 4'b0010, 4'b1111, 1));
    // Back-to-back flag setters, then a flush on a flag setter without stall.
    cycle(0, 0, 0, mk(1, 64'h1, 5'd4, 4'b1000, 4'b1001, 1));
    cycle(0, 0, 0, mk(1, 64'h2, 5'd5, 4'b1000, 4'b0110, 1));
    cycle(0, 0, 1, mk(1, 64'h3, 5'd6, 4'b1000, 4'b1111, 1));
    // Invalid op with control bits set must not carry control into MEM.
    cycle(0, 0, 0, mk(0, 64'hDEAD, 5'd31, 4'b1111, 4'b1111, 1));
    // Reset while an operation is held by stall, then the first advance.
    cycle(0, 0, 0, a);
    cycle(0, 1, 0, b);
    cycle(1, 1, 0, b);
    cycle(0, 0, 0, mk(1, 64'h42, 5'd9, 4'b0101, 4'b0011, 1));
    // Counter wrap on the 4-bit instance: 15 advances from reset, then one more.
    cycle(1, 0, 0, bubble());
    repeat (15) cycle(0, 0, 0, mk(1, 64'h10, 5'd1, 4'b1000, 4'b0000, 0));
    cycle(0, 0, 0, mk(1, 64'h11, 5'd2, 4'b1000, 4'b0000, 0));
    cycle(0, 0, 0, mk(1, 64'h12, 5'd3, 4'b1000, 4'b0000, 0));
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(49) == 0), ($urandom_range(3) == 0), ($urandom_range(9) == 0), rand_op());
    end

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d entries left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 Parameter: DATA_W, default 64; datapath width of result and store data.
REQ-002 Parameter: CNT_W, default 32; width of the retired-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard unit: hold all stage state this cycle.
REQ-006 flush  input  1  squash the operation currently in EX.
REQ-007 ex_valid  input  1  EX holds a real operation.
REQ-008 ex_result  input  DATA_W  ALU result.
REQ-009 ex_negative, ex_zero, ex_overflow, ex_carry_out  input  1 each  ALU flags.
REQ-010 ex_set_flags  input  1  operation is ADDS/SUBS/ANDS; it updates the flag register.
REQ-011 ex_store_data  input  DATA_W  register data for STUR.
REQ-012 ex_rd  input  5  destination register number.
REQ-013 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  input  1 each  control bits.
REQ-014 mem_valid  output  1  MEM holds a real operation.
REQ-015 mem_result, mem_store_data  output  DATA_W  registered copies.
REQ-016 mem_rd  output  5; mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  output  1 each.
REQ-017 flags_q  output  4  architectural flags {N,Z,V,C}, registered.
REQ-018 flags_fwd  output  4  flags seen by B.cond resolving this cycle.
REQ-019 retire_count  output  CNT_W  number of valid operations accepted into MEM.

Function
REQ-020 Priority per edge SHALL be reset > flush > stall > normal advance.
REQ-021 Normal advance (no stall, no flush): every mem_* output SHALL take its ex_* counterpart; mem_valid SHALL take ex_valid; latency exactly one cycle.
REQ-022 Control outputs (mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg) SHALL be forced 0 whenever the captured ex_valid is 0.
REQ-023 Stall without flush: all registers, flags_q and retire_count SHALL hold.
REQ-024 Flush (regardless of stall): mem_valid and all control outputs SHALL become 0; mem_result, mem_store_data, mem_rd SHALL become 0; flags_q and retire_count SHALL hold.
REQ-025 flags_q SHALL load {ex_negative, ex_zero, ex_overflow, ex_carry_out} only on a normal advance with ex_valid=1 and ex_set_flags=1; otherwise hold.
REQ-026 flags_fwd SHALL be combinational: new EX flags when ex_valid=1, ex_set_flags=1, flush=0; else flags_q (stall does not block forwarding).
REQ-027 retire_count SHALL increment by 1 on each normal advance with ex_valid=1, wrapping from all-ones to 0 without a flag.
REQ-028 An operation held under stall SHALL be captured exactly once when stall deasserts; no duplication, no loss.
REQ-029 Two back-to-back flag-setting operations SHALL leave flags_q equal to the second's flags after both advance.
REQ-030 A flush asserted in the same cycle as a flag-setting operation SHALL suppress its flag update and its count.

Reset
REQ-031 With reset=1 at an edge: mem_valid, all control outputs, mem_result, mem_store_data, mem_rd, flags_q (4'b0000) and retire_count SHALL become 0, overriding stall and flush.
REQ-032 Reset asserted mid-stall SHALL discard the held operation; first advance after reset release SHALL capture the EX inputs of that cycle.
REQ-033 No output SHALL be X after the first reset edge.

Verification
REQ-034 Advance: ex_valid=1, ex_result=64'h5, ex_rd=3, ex_reg_write=1 -> next cycle mem_result=5, mem_rd=3, mem_reg_write=1, mem_valid=1, retire_count=1.
REQ-035 Flags: SUBS with ex_zero=1, ex_carry_out=1, ex_set_flags=1 -> flags_fwd=4'b0101 same cycle; flags_q=4'b0101 next cycle; following ADD (set_flags=0) leaves 4'b0101.
REQ-036 Stall: capture op A, hold stall 3 cycles with new EX inputs B -> mem_* stays A, retire_count unchanged; release -> B captured once, count +1.
REQ-037 Flush+stall: stall=1, flush=1 with ex_valid=1, ex_mem_write=1, ex_set_flags=1 -> mem_valid=0, mem_mem_write=0, flags_q and retire_count unchanged.
REQ-038 Wrap: preload retire_count to all-ones via CNT_W=4 instance and 15 advances, one more advance -> 0.
REQ-039 Reset: reset=1 during stall with valid op held -> all outputs 0 next cycle, flags_q=0.
